sl_rx_ctrl: RTL and testbench
=============================

Name: sl_rx_ctrl

Overview:
Host-side controller for the serial-line (SL) receiver. It owns the receiver's configuration register and applies config writes only between words. It detects word-complete and error events from the receiver status and buffers good words in a small FIFO. It exposes a one-hot-addressed register port and an interrupt to the host CPU/bus bridge.

Parameters:
FIFO_DEPTH, 4, data FIFO entries (power of two, 2..16)
CFG_RESET, 16'h0020, config value after reset (PCE=0, BQ=16)

Ports:
clk  in  1  system clock (16 MHz)
rst_n  in  1  asynchronous active-low reset
addr  in  4  one-hot register select: 0001 CONFIG, 0010 DATA_WR, 0100 DATA_R, 1000 STATUS
wr_en  in  1  write strobe, one cycle
rd_en  in  1  read strobe, one cycle
wdata  in  32  write data
rdata  out  32  read data, registered
rd_valid  out  1  rdata valid pulse
irq  out  1  interrupt request
rx_config_w  out  16  config driven to receiver
rx_status_w  in  16  receiver status (WLC=0, WRP=1, WRF=3, PEF=4, LEF=5)
rx_data_w  in  32  receiver buffered word
tx_data_w  out  32  word for transmitter
tx_start  out  1  transmit request pulse

Behaviour:
- Reset (async): rdata=0, rd_valid=0, irq=0, rx_config_w=CFG_RESET, tx_data_w=0, tx_start=0, FIFO empty, all sticky flags 0, no pending config.
- Config fields: PCE bit0, BQ bits[6:1], MODE bit7, IRQM bit8. Bits [15:9] are read-only 0.
- CONFIG write: use wdata[8:0]. If BQ==0 or BQ>32, reject the write, leave config unchanged and set sticky CFE.
  - If rx_status_w[WRP]==0, apply on the next clk.
  - Else store in the pending register and apply on the first cycle WRP==0.
  - A second write while pending overwrites the pending value.
- DATA_WR write: if MODE==1, latch tx_data_w=wdata and pulse tx_start for 1 cycle. If MODE==0, ignore.
- Events: register rx_status_w each cycle and detect rising edges.
  - WRF rise with PEF=0 and WLC=0: push rx_data_w into the FIFO.
  - WRF rise with PEF=1: set sticky PER, no push.
  - WRF rise with WLC=1: set sticky LER, no push.
  - LEF rise: set sticky VER.
- FIFO full on push: drop the word and set sticky OVF. Exception: a push and a pop in the same cycle while full → both succeed, no OVF.
- DATA_R read: rdata=FIFO head, then pop. If empty: rdata=0, no pop, no flag.
- STATUS read: rdata = {16'b0, count[4:0] at [12:8], CFE[7], WRP live[6], VER[5], LER[4], PER[3], OVF[2], full[1], empty[0]}. The read clears all sticky flags.
  - A sticky set in the same cycle as the clear: the set wins.
- CONFIG read: rdata = {16'b0, current applied config}. DATA_WR read returns tx_data_w.
- Read latency: rd_valid and rdata appear 1 cycle after rd_en.
- addr not exactly one-hot: access ignored; a read still returns rdata=0 with rd_valid.
- wr_en and rd_en together: write is performed, read is ignored, no rd_valid.
- IRQ:
  - IRQM=0: level, irq = !empty | OVF | PER | LER | VER | CFE, registered.
  - IRQM=1: 1-cycle pulse per accepted push or per new sticky set. Multiple events in one cycle give one pulse.
- Reset mid-word: all state clears immediately, and the pending config is discarded.

Test Plan:
- Reset, read CONFIG → rdata=0x0000_0020, rd_valid 1 cycle after rd_en. Read STATUS → 0x0000_0001.
- Drive 3 WRF rising edges with data 0xA5A5_0001/2/3, PEF=WLC=0, then 3× DATA_R reads → those words in order. A 4th read → 0, empty=1.
- Push 5 words with FIFO_DEPTH=4 → STATUS shows count=4, full=1, OVF=1. Second STATUS read shows OVF=0.
- Write CONFIG=0x0041 while WRP=1 → rx_config_w stays 0x0020 until WRP falls, then becomes 0x0041 the next cycle. Write with BQ=0 → config unchanged, CFE=1.
- WRF rise with PEF=1 under IRQM=1 → no push, PER=1, irq single 1-cycle pulse. Same event under IRQM=0 → irq held high until STATUS read.
- Assert rst_n low mid-burst with FIFO holding 2 words → all outputs at reset values immediately, FIFO empty after release.

Source files
------------

// File: rtl/sl_rx_ctrl.sv
// Host-side controller for the serial-line receiver: config register with
// deferred apply, event detection, good-word FIFO, register port and interrupt.
module sl_rx_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] CFG_RESET  = 16'h0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        irq,
    output logic [15:0] rx_config_w,
    input  logic [15:0] rx_status_w,
    input  logic [31:0] rx_data_w,
    output logic [31:0] tx_data_w,
    output logic        tx_start
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    localparam logic [3:0] ADDR_CFG  = 4'b0001;
    localparam logic [3:0] ADDR_DWR  = 4'b0010;
    localparam logic [3:0] ADDR_DR   = 4'b0100;
    localparam logic [3:0] ADDR_STAT = 4'b1000;

    // Sticky flag positions inside sticky_reg
    localparam int S_OVF = 0;
    localparam int S_PER = 1;
    localparam int S_LER = 2;
    localparam int S_VER = 3;
    localparam int S_CFE = 4;

    logic [8:0]        cfg_reg;
    logic [8:0]        pend_reg;
    logic              pend_valid_reg;
    logic [31:0]       tx_data_reg;
    logic              tx_start_reg;
    logic              wrf_q_reg;
    logic              lef_q_reg;
    logic [31:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_reg;
    logic [PTR_W-1:0]  rptr_reg;
    logic [4:0]        count_reg;
    logic [4:0]        count_next;
    logic [4:0]        sticky_reg;
    logic [4:0]        sticky_next;
    logic [4:0]        set_vec;
    logic [31:0]       rdata_reg;
    logic              rd_valid_reg;
    logic              irq_reg;
    logic              irq_next;
    logic [31:0]       rd_word;

    logic sel_cfg, sel_dwr, sel_dr, sel_st, sel_any;
    logic rd_ok;
    logic cfg_wr, bq_ok, cfe_set;
    logic wrp, pef, wlc;
    logic wrf_rise, lef_rise;
    logic push_req, push_ok, pop, ovf_set;
    logic full, empty;
    logic sticky_clr;
    logic unused_status;

    assign unused_status = ^{rx_status_w[15:6], rx_status_w[2]};

    assign sel_cfg = (addr == ADDR_CFG);
    assign sel_dwr = (addr == ADDR_DWR);
    assign sel_dr  = (addr == ADDR_DR);
    assign sel_st  = (addr == ADDR_STAT);
    assign sel_any = sel_cfg | sel_dwr | sel_dr | sel_st;

    // A simultaneous write strobe suppresses the read entirely
    assign rd_ok = rd_en & ~wr_en;

    assign wrp = rx_status_w[1];
    assign pef = rx_status_w[4];
    assign wlc = rx_status_w[0];

    assign cfg_wr  = wr_en & sel_cfg;
    assign bq_ok   = (wdata[6:1] != 6'd0) && (wdata[6:1] <= 6'd32);
    assign cfe_set = cfg_wr & ~bq_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg        <= CFG_RESET[8:0];
            pend_reg       <= 9'd0;
            pend_valid_reg <= 1'b0;
        end else if (cfg_wr && bq_ok) begin
            if (!wrp) begin
                cfg_reg        <= wdata[8:0];
                pend_valid_reg <= 1'b0;
            end else begin
                pend_reg       <= wdata[8:0];
                pend_valid_reg <= 1'b1;
            end
        end else if (pend_valid_reg && !wrp) begin
            cfg_reg        <= pend_reg;
            pend_valid_reg <= 1'b0;
        end
    end

    assign rx_config_w = {7'd0, cfg_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_reg  <= 32'd0;
            tx_start_reg <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            if (wr_en && sel_dwr && cfg_reg[7]) begin
                tx_data_reg  <= wdata;
                tx_start_reg <= 1'b1;
            end
        end
    end

    assign tx_data_w = tx_data_reg;
    assign tx_start  = tx_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrf_q_reg <= 1'b0;
            lef_q_reg <= 1'b0;
        end else begin
            wrf_q_reg <= rx_status_w[3];
            lef_q_reg <= rx_status_w[5];
        end
    end

    assign wrf_rise = rx_status_w[3] & ~wrf_q_reg;
    assign lef_rise = rx_status_w[5] & ~lef_q_reg;

    assign full     = (count_reg == DEPTH_C);
    assign empty    = (count_reg == 5'd0);
    assign push_req = wrf_rise & ~pef & ~wlc;
    assign pop      = rd_ok & sel_dr & ~empty;
    // When full, a same-cycle pop frees the slot the push lands in
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    assign count_next = count_reg + {4'd0, push_ok} - {4'd0, pop};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wptr_reg] <= rx_data_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= 5'd0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign set_vec[S_OVF] = ovf_set;
    assign set_vec[S_PER] = wrf_rise & pef;
    assign set_vec[S_LER] = wrf_rise & wlc;
    assign set_vec[S_VER] = lef_rise;
    assign set_vec[S_CFE] = cfe_set;

    assign sticky_clr = rd_ok & sel_st;

    // Set dominates a same-cycle clear from a STATUS read
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sticky
            assign sticky_next[gi] = (sticky_clr ? 1'b0 : sticky_reg[gi]) | set_vec[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 5'd0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    always_comb begin
        rd_word = 32'd0;
        if (sel_cfg) begin
            rd_word = {16'd0, rx_config_w};
        end else if (sel_dwr) begin
            rd_word = tx_data_reg;
        end else if (sel_dr) begin
            rd_word = empty ? 32'd0 : mem_reg[rptr_reg];
        end else if (sel_st) begin
            rd_word = {16'd0, 3'd0, count_reg, sticky_reg[S_CFE], wrp,
                       sticky_reg[S_VER], sticky_reg[S_LER], sticky_reg[S_PER],
                       sticky_reg[S_OVF], full, empty};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg    <= 32'd0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_ok;
            if (rd_ok) begin
                rdata_reg <= sel_any ? rd_word : 32'd0;
            end
        end
    end

    assign rdata    = rdata_reg;
    assign rd_valid = rd_valid_reg;

    always_comb begin
        if (cfg_reg[8]) begin
            irq_next = push_ok | (|(set_vec & ~sticky_reg));
        end else begin
            irq_next = (count_next != 5'd0) | (|sticky_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_next;
        end
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Directed bench for sl_rx_ctrl: register port, FIFO, config deferral, irq modes, reset.
`timescale 1ns/1ps
module tb_sl_rx_ctrl;

    localparam logic [3:0] A_CFG  = 4'b0001;
    localparam logic [3:0] A_DWR  = 4'b0010;
    localparam logic [3:0] A_DR   = 4'b0100;
    localparam logic [3:0] A_STAT = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        irq;
    logic [15:0] rx_config_w;
    logic [15:0] rx_status_w;
    logic [31:0] rx_data_w;
    logic [31:0] tx_data_w;
    logic        tx_start;

    int checks = 0;
    int errors = 0;
    logic [15:0] st_base;

    sl_rx_ctrl #(.FIFO_DEPTH(4), .CFG_RESET(16'h0020)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .irq(irq),
        .rx_config_w(rx_config_w), .rx_status_w(rx_status_w), .rx_data_w(rx_data_w),
        .tx_data_w(tx_data_w), .tx_start(tx_start)
    );

    initial clk = 1'b0;
    always #31.25 clk = ~clk;

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; addr = 4'd0;
        d = rdata; v = rd_valid;
        $display("rd addr=%b data=%h valid=%b", a, d, v);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; addr = 4'd0;
        $display("wr addr=%b data=%h", a, d);
    endtask

    task automatic rx_event(input logic [31:0] d, input logic p, input logic l);
        @(negedge clk);
        rx_data_w = d;
        rx_status_w = st_base | 16'h0008 | {11'd0, p, 3'd0, l};
        @(negedge clk);
        rx_status_w = st_base;
        $display("rx word=%h pef=%b wlc=%b", d, p, l);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        checks++;
        if (rdata !== 32'd0 || rd_valid !== 1'b0 || irq !== 1'b0 || tx_start !== 1'b0 ||
            tx_data_w !== 32'd0 || rx_config_w !== 16'h0020) begin
            errors++;
            $display("FAIL reset_outputs rdata=%h rd_valid=%b irq=%b cfg=%h tx=%h/%b exp 0/0/0/0020/0/0",
                     rdata, rd_valid, irq, rx_config_w, tx_data_w, tx_start);
        end
        bus_read(A_CFG, d, v);
        checks++;
        if (d !== 32'h0000_0020 || v !== 1'b1) begin
            errors++; $display("FAIL reset_cfg_read got %h/%b exp 00000020/1", d, v);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_pulse got %b exp 0", rd_valid);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0001 || v !== 1'b1) begin
            errors++; $display("FAIL reset_status got %h/%b exp 00000001/1", d, v);
        end
    endtask

    task automatic test_fifo_order();
        logic [31:0] d; logic v;
        logic [31:0] exp_w [3] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
        for (int i = 0; i < 3; i++) rx_event(exp_w[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus_read(A_DR, d, v);
            checks++;
            if (d !== exp_w[i] || v !== 1'b1) begin
                errors++; $display("FAIL fifo_word%0d got %h/%b exp %h/1", i, d, v, exp_w[i]);
            end
        end
        bus_read(A_DR, d, v);
        checks++;
        if (d !== 32'd0 || v !== 1'b1) begin
            errors++; $display("FAIL fifo_empty_read got %h/%b exp 0/1", d, v);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++; $display("FAIL fifo_empty_status got %h exp 00000001", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic v;
        for (int i = 0; i < 5; i++) rx_event(32'h100 + i, 1'b0, 1'b0);
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0406) begin
            errors++; $display("FAIL ovf_status got %h exp 00000406", d);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0402) begin
            errors++; $display("FAIL ovf_cleared got %h exp 00000402", d);
        end
        // Full FIFO: push and pop in the same cycle both take effect
        @(negedge clk);
        rx_data_w = 32'h0000_0BEE;
        rx_status_w = st_base | 16'h0008;
        addr = A_DR; rd_en = 1'b1;
        @(negedge clk);
        rx_status_w = st_base; rd_en = 1'b0; addr = 4'd0;
        checks++;
        if (rdata !== 32'h100 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL pushpop_head got %h/%b exp 00000100/1", rdata, rd_valid);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0402) begin
            errors++; $display("FAIL pushpop_status got %h exp 00000402", d);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DR, d, v);
            checks++;
            if (d !== ((i == 3) ? 32'h0BEE : 32'h101 + i)) begin
                errors++; $display("FAIL drain_word%0d got %h exp %h", i, d,
                                   (i == 3) ? 32'h0BEE : 32'h101 + i);
            end
        end
    endtask

    task automatic test_config();
        logic [31:0] d; logic v;
        st_base = 16'h0002;
        rx_status_w = st_base;
        bus_write(A_CFG, 32'h0000_0005);
        bus_write(A_CFG, 32'h0000_0041);
        repeat (3) @(negedge clk);
        checks++;
        if (rx_config_w !== 16'h0020) begin
            errors++; $display("FAIL cfg_held got %h exp 0020", rx_config_w);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0041) begin
            errors++; $display("FAIL status_wrp got %h exp 00000041", d);
        end
        st_base = 16'h0000;
        rx_status_w = st_base;
        @(negedge clk);
        checks++;
        if (rx_config_w !== 16'h0041) begin
            errors++; $display("FAIL cfg_applied got %h exp 0041", rx_config_w);
        end
        bus_write(A_CFG, 32'h0000_0081);
        bus_write(A_CFG, 32'h0000_0042);
        bus_read(A_CFG, d, v);
        checks++;
        if (d !== 32'h0000_0041) begin
            errors++; $display("FAIL cfg_reject got %h exp 00000041", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL cfe_irq_level got %b exp 1", irq);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0081) begin
            errors++; $display("FAIL cfe_status got %h exp 00000081", d);
        end
        bus_write(A_CFG, 32'h0000_00A1);
        checks++;
        if (rx_config_w !== 16'h00A1) begin
            errors++; $display("FAIL cfg_immediate got %h exp 00A1", rx_config_w);
        end
    endtask

    task automatic test_data_wr();
        logic [31:0] d; logic v;
        bus_write(A_DWR, 32'hDEAD_BEEF);
        checks++;
        if (tx_start !== 1'b1 || tx_data_w !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL tx_start_mode1 got %h/%b exp deadbeef/1", tx_data_w, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            errors++; $display("FAIL tx_start_width got %b exp 0", tx_start);
        end
        bus_read(A_DWR, d, v);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dwr_read got %h exp deadbeef", d);
        end
        bus_write(A_CFG, 32'h0000_0021);
        bus_write(A_DWR, 32'h1234_5678);
        checks++;
        if (tx_start !== 1'b0 || tx_data_w !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL tx_mode0_ignored got %h/%b exp deadbeef/0", tx_data_w, tx_start);
        end
    endtask

    task automatic test_bus_corner();
        logic [31:0] d; logic v;
        bus_read(4'b0011, d, v);
        checks++;
        if (d !== 32'd0 || v !== 1'b1) begin
            errors++; $display("FAIL bad_addr_read got %h/%b exp 0/1", d, v);
        end
        @(negedge clk);
        addr = A_DWR; wdata = 32'h0; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_together rd_valid=%b exp 0", rd_valid);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic v;
        bus_write(A_CFG, 32'h0000_0121);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle_pulse got %b exp 0", irq);
        end
        @(negedge clk);
        rx_data_w = 32'hBAD0_0001;
        rx_status_w = st_base | 16'h0018;
        @(negedge clk);
        rx_status_w = st_base;
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_pulse_high got %b exp 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_pulse_low got %b exp 0", irq);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0009) begin
            errors++; $display("FAIL per_status got %h exp 00000009", d);
        end
        bus_write(A_CFG, 32'h0000_0021);
        rx_event(32'hBAD0_0002, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_level_held got %b exp 1", irq);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0009 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_level_clear got %h/%b exp 00000009/0", d, irq);
        end
        rx_event(32'hBAD0_0003, 1'b0, 1'b1);
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0011) begin
            errors++; $display("FAIL ler_status got %h exp 00000011", d);
        end
        @(negedge clk);
        rx_status_w = st_base | 16'h0020;
        @(negedge clk);
        rx_status_w = st_base;
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0021) begin
            errors++; $display("FAIL ver_status got %h exp 00000021", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        rx_event(32'h0000_0AAA, 1'b0, 1'b0);
        rx_event(32'h0000_0BBB, 1'b0, 1'b0);
        bus_read(A_CFG, d, v);
        st_base = 16'h0002;
        rx_status_w = st_base;
        bus_write(A_CFG, 32'h0000_0041);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'd0 || rd_valid !== 1'b0 || irq !== 1'b0 || rx_config_w !== 16'h0020 ||
            tx_data_w !== 32'd0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid rdata=%h irq=%b cfg=%h tx=%h exp 0/0/0020/0",
                     rdata, irq, rx_config_w, tx_data_w);
        end
        st_base = 16'h0000;
        rx_status_w = st_base;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(A_STAT, d, v);
        checks++;
        if (d !== 32'h0000_0001 || rx_config_w !== 16'h0020) begin
            errors++; $display("FAIL reset_mid_after got %h/%h exp 00000001/0020", d, rx_config_w);
        end
    endtask

    initial begin
        rst_n = 1'b0; addr = 4'd0; wr_en = 1'b0; rd_en = 1'b0; wdata = 32'd0;
        st_base = 16'h0000; rx_status_w = 16'h0000; rx_data_w = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fifo_order();
        test_overflow();
        test_config();
        test_data_wr();
        test_bus_corner();
        test_irq();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
